div_sched: RTL
==============

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 The block SHALL have one parameter: DZ_FAST, default 1, meaning divide-by-zero completes without iterating (0 = run all 16 steps, then flag).
REQ-002 The block SHALL have the following ports, clock and reset first:
- CLK_1ms  in  1  sole clock, all state on rising edge
- RST  in  1  reset; one clock; reset is asynchronous and active-high
- REQ_A  in  1  requester A operation request, level
- DIVIDEND_A  in  16  requester A dividend
- DIVISOR_A  in  8  requester A divisor
- ACK_A  out  1  one-cycle pulse: A's operands captured
- REQ_B  in  1  requester B operation request, level
- DIVIDEND_B  in  16  requester B dividend
- DIVISOR_B  in  8  requester B divisor
- ACK_B  out  1  one-cycle pulse: B's operands captured
- BUSY  out  1  high whenever state is not IDLE
- DONE  out  1  one-cycle pulse: result valid
- DONE_ID  out  1  owner of the result (0=A, 1=B), valid with DONE
- QUOTIENT  out  8  quotient, low 8 bits
- REMAINDER  out  8  remainder
- DZ  out  1  divide-by-zero flag
- DO  out  1  overflow flag: true quotient > 255

Function
REQ-003 The FSM SHALL have the states IDLE, RUN and FIN; no other states are reachable.
REQ-004 In IDLE, at an edge where REQ_A or REQ_B is high, the block SHALL capture the granted requester's operands, pulse its ACK for the following cycle, and go to RUN with step counter 0.
REQ-005 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; the last-grant register resets to B, so A wins the first tie.
REQ-006 Operands SHALL be sampled only at the grant edge; later operand changes SHALL NOT affect the operation in flight.
REQ-007 A REQ still high in the cycle after its ACK SHALL be treated as a new request, eligible once the block returns to IDLE.
REQ-008 RUN SHALL perform one restoring shift-subtract step per cycle on a 24-bit work register {rem[7:0], dvd[15:0]}:
- shift left by 1
- if rem >= divisor: subtract divisor from rem and set bit 0
RUN SHALL last exactly 16 cycles, then go to FIN.
REQ-009 In FIN, the block SHALL register the result outputs, pulse DONE with DONE_ID for one cycle, and return to IDLE on the next edge.
REQ-010 Latency: with a grant at edge k, DONE SHALL be high between edges k+17 and k+18; sustained throughput SHALL be one operation per 18 cycles.
REQ-011 Overflow: if the 16-bit quotient exceeds 255, the block SHALL set DO=1, DZ=0, QUOTIENT=quotient[7:0], REMAINDER=true remainder.
REQ-012 Divide-by-zero with DZ_FAST=1: the grant edge SHALL go directly to FIN, DONE SHALL occur at edge k+1, and outputs SHALL be DZ=1, DO=0, QUOTIENT=0, REMAINDER=0.
REQ-013 Divide-by-zero with DZ_FAST=0: the block SHALL use normal RUN timing, and the outputs SHALL be as in REQ-012.
REQ-014 Normal completion SHALL clear DZ and DO.
REQ-015 QUOTIENT, REMAINDER, DZ, DO and DONE_ID SHALL hold their values until the next FIN.
REQ-016 The block SHALL ignore requests while BUSY; it SHALL NOT queue them.

Reset
REQ-017 While RST is high, the block SHALL asynchronously force: state IDLE, step counter 0, last-grant=B, all outputs 0.
REQ-018 RST asserted mid-RUN SHALL abort the operation with no DONE, and the aborted requester SHALL NOT receive a result.
REQ-019 After RST falls, the first grant SHALL occur at the first edge with a request.

Structure
REQ-020 A shared package div_pkg SHALL hold:
- the state enum (IDLE/RUN/FIN)
- requester ID constants ID_A=0, ID_B=1
- DIV_STEPS=16
- width constants: dividend 16, divisor/quotient/remainder 8
REQ-021 The shift-subtract step (work register, compare, subtract, step counter) SHALL be the sub-module div_core; the FSM and arbiter SHALL live in div_sched.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- A requests 100/7 -> ACK_A the next cycle; DONE at k+17 with DONE_ID=0, Q=14, R=2, DZ=0, DO=0
- B requests 1000/3 -> DO=1, Q=77 (333 mod 256), R=1, DZ=0
- A requests 65535/255 -> DO=1, Q=1, R=0
- A requests 5/0 with DZ_FAST=1 -> DONE at k+1, DZ=1, Q=0, R=0; same with DZ_FAST=0 -> DONE at k+17
- A and B request together from reset, held high -> A is served first, then B; DONE_IDs are 0 then 1; B's ACK comes after A's DONE
- RST pulsed 8 cycles into RUN -> no DONE; BUSY=0; outputs 0; a new A request of 9/2 then gives Q=4, R=1

Source files
------------

// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared types and constants for the div_sched divider block
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DVD_W     = 16;
  localparam int DVS_W     = 8;
  localparam int QUO_W     = 8;
  localparam int REM_W     = 8;
  localparam int DIV_STEPS = 16;
  localparam int STEP_W    = 4;
  localparam int WORK_W    = REM_W + DVD_W;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Anything above the reported quotient width means the result was truncated.
  function automatic logic quo_overflow(input logic [DVD_W-1:0] quo);
    return |quo[DVD_W-1:QUO_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_core.sv
// ============================================================================
// div_core : restoring shift-subtract datapath, one quotient bit per step
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module div_core
  import div_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic [DVD_W-1:0] quo_o,
  output logic [REM_W-1:0] rem_o,
  output logic             last_o
);

  logic [WORK_W-1:0] work_q, work_d;
  logic [DVS_W-1:0]  divisor_q, divisor_d;
  logic [STEP_W-1:0] step_q, step_d;

  logic [REM_W:0]    w_partial;
  logic [REM_W:0]    w_diff;
  logic              w_ge;

  // The shifted remainder needs one extra bit: 2*rem+1 can exceed 255
  // even though rem itself always stays below the divisor.
  assign w_partial = {work_q[WORK_W-1:DVD_W], work_q[DVD_W-1]};
  assign w_diff    = w_partial - {1'b0, divisor_q};
  assign w_ge      = (w_partial >= {1'b0, divisor_q});

  always_comb begin
    work_d    = work_q;
    divisor_d = divisor_q;
    step_d    = step_q;
    if (load_i) begin
      work_d    = {{REM_W{1'b0}}, dividend_i};
      divisor_d = divisor_i;
      step_d    = '0;
    end else if (step_i) begin
      work_d = {(w_ge ? w_diff[REM_W-1:0] : w_partial[REM_W-1:0]),
                work_q[DVD_W-2:0], w_ge};
      step_d = step_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      work_q    <= '0;
      divisor_q <= '0;
      step_q    <= '0;
    end else begin
      work_q    <= work_d;
      divisor_q <= divisor_d;
      step_q    <= step_d;
    end
  end

  assign quo_o  = work_q[DVD_W-1:0];
  assign rem_o  = work_q[WORK_W-1:DVD_W];
  assign last_o = step_i && (step_q == STEP_W'(DIV_STEPS - 1));

endmodule

`default_nettype wire

// File: rtl/div_sched.sv
// ============================================================================
// div_sched : two-requester round-robin scheduler around a 16/8 divider
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module div_sched
  import div_pkg::*;
#(
  parameter int unsigned DZ_FAST = 1
) (
  input  logic             CLK_1ms,
  input  logic             RST,
  input  logic             REQ_A,
  input  logic [DVD_W-1:0] DIVIDEND_A,
  input  logic [DVS_W-1:0] DIVISOR_A,
  output logic             ACK_A,
  input  logic             REQ_B,
  input  logic [DVD_W-1:0] DIVIDEND_B,
  input  logic [DVS_W-1:0] DIVISOR_B,
  output logic             ACK_B,
  output logic             BUSY,
  output logic             DONE,
  output logic             DONE_ID,
  output logic [QUO_W-1:0] QUOTIENT,
  output logic [REM_W-1:0] REMAINDER,
  output logic             DZ,
  output logic             DO
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              zero_q, zero_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              done_q, done_d;
  logic              done_id_q, done_id_d;
  logic [QUO_W-1:0]  quo_q, quo_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              dz_q, dz_d;
  logic              do_q, do_d;

  logic              w_req_any;
  logic              w_gnt_b;
  logic [DVD_W-1:0]  w_dvd;
  logic [DVS_W-1:0]  w_dvs;
  logic              w_zero;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [DVD_W-1:0]  w_core_quo;
  logic [REM_W-1:0]  w_core_rem;

  // B wins only when A is idle or A held the previous grant.
  assign w_req_any = REQ_A | REQ_B;
  assign w_gnt_b   = REQ_B && (!REQ_A || (last_q == ID_A));
  assign w_dvd     = w_gnt_b ? DIVIDEND_B : DIVIDEND_A;
  assign w_dvs     = w_gnt_b ? DIVISOR_B  : DIVISOR_A;
  assign w_zero    = (w_dvs == '0);
  assign w_load    = (state_q == ST_IDLE) && w_req_any;
  assign w_step    = (state_q == ST_RUN);

  div_core u_core (
    .clk_i      (CLK_1ms),
    .rst_i      (RST),
    .load_i     (w_load),
    .step_i     (w_step),
    .dividend_i (w_dvd),
    .divisor_i  (w_dvs),
    .quo_o      (w_core_quo),
    .rem_o      (w_core_rem),
    .last_o     (w_last)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    zero_d    = zero_q;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    do_d      = do_q;
    case (state_q)
      ST_IDLE: begin
        if (w_req_any) begin
          last_d  = w_gnt_b ? ID_B : ID_A;
          owner_d = w_gnt_b ? ID_B : ID_A;
          zero_d  = w_zero;
          ack_a_d = !w_gnt_b;
          ack_b_d = w_gnt_b;
          state_d = ((DZ_FAST != 0) && w_zero) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        done_id_d = owner_q;
        if (zero_q) begin
          quo_d = '0;
          rem_d = '0;
          dz_d  = 1'b1;
          do_d  = 1'b0;
        end else begin
          quo_d = w_core_quo[QUO_W-1:0];
          rem_d = w_core_rem;
          dz_d  = 1'b0;
          do_d  = quo_overflow(w_core_quo);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_1ms or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      last_q    <= ID_B;
      owner_q   <= ID_A;
      zero_q    <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
      do_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      zero_q    <= zero_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
      do_q      <= do_d;
    end
  end

  assign ACK_A     = ack_a_q;
  assign ACK_B     = ack_b_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = done_q;
  assign DONE_ID   = done_id_q;
  assign QUOTIENT  = quo_q;
  assign REMAINDER = rem_q;
  assign DZ        = dz_q;
  assign DO        = do_q;

endmodule

`default_nettype wire
